diners_ring: RTL and testbench

- Parametrised N-philosopher ring implementing the THINKING/HUNGRY/EATING/READING protocol, with a per-philosopher pending monitor.
- Adds three things the fixed 3-philosopher model lacks:
  - synthesizable request inputs in place of nondeterministic choice;
  - per-philosopher hungry-wait counters with a starvation flag;
  - an optional age-priority mode that lets a long-waiting philosopher win over its right neighbour.
- Used as the DUT for property checks (mutual exclusion, starvation) and as a stimulus-driven simulation model.

---
 rtl/diners_ring.sv | 152 +++++++++++++++
 tb/tb_diners_ring.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/diners_ring.sv
// diners_ring: N-philosopher ring running the THINKING / HUNGRY / EATING /
// READING protocol. Each philosopher has a saturating hungry-wait counter
// with a starvation flag, a pending monitor bit, and optional age priority
// when two HUNGRY neighbours contend. A sticky flag records any cycle in
// which two ring-adjacent philosophers were EATING together.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst_n        asynchronous active-low reset
//   hungry_req   [N]   THINKING philosopher i becomes HUNGRY when bit i=1
//   done_req     [N]   EATING philosopher i returns to THINKING when bit i=1
//   state_o      [2N]  per-philosopher state, bits [2i+1:2i] = philosopher i
//                      (THINKING=0, HUNGRY=1, EATING=2, READING=3)
//   pending_o    [N]   set once HUNGRY is seen, cleared once THINKING is seen
//   starved_o    [N]   wait counter at or above STARVE_LIM
//   violation_o        sticky: adjacent philosophers were EATING together
//
// Neighbours: left L(i) = (i+1) mod N, right R(i) = (i+N-1) mod N.
// There is no handshake: requests are level-sampled on every posedge and
// only take effect in the state that consumes them.
module diners_ring #(
  parameter int N = 3,
  parameter int WAIT_W = 4,
  parameter int STARVE_LIM = 8,
  parameter int PRIO_EN = 0,
  parameter logic [2*N-1:0] INIT = 6'b01_11_10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   hungry_req,
  input  logic [N-1:0]   done_req,
  output logic [2*N-1:0] state_o,
  output logic [N-1:0]   pending_o,
  output logic [N-1:0]   starved_o,
  output logic           violation_o
);

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    HUNGRY   = 2'd1,
    EATING   = 2'd2,
    READING  = 2'd3
  } phil_state_e;

  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(STARVE_LIM);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  phil_state_e       state_q [N];
  phil_state_e       state_d [N];
  logic [WAIT_W-1:0] wait_q  [N];
  logic [WAIT_W-1:0] wait_d  [N];
  logic [N-1:0]      pending_q, pending_d;
  logic              violation_q, violation_d;
  logic [N-1:0]      r_wins;
  logic [N-1:0]      can_eat;

  // r_wins[j]: philosopher j wins a HUNGRY-vs-HUNGRY contention against its
  // left neighbour. Without age priority the right member of a pair always
  // wins; with it, a strictly older left neighbour takes the pair instead.
  always_comb begin
    r_wins = '1;
    if (PRIO_EN != 0) begin
      for (int j = 0; j < N; j++) begin
        r_wins[j] = !(wait_q[(j + 1) % N] > wait_q[j]);
      end
    end
  end

  // A HUNGRY philosopher may start eating when neither neighbour is EATING
  // and it does not lose the contention with a HUNGRY neighbour on either
  // side. The pair (R, i) is decided by r_wins[R]; the pair (i, L) by r_wins[i].
  always_comb begin
    can_eat = '0;
    for (int i = 0; i < N; i++) begin
      can_eat[i] = (state_q[(i + 1) % N] != EATING) &&
                   (state_q[(i + N - 1) % N] != EATING) &&
                   !((state_q[(i + N - 1) % N] == HUNGRY) && r_wins[(i + N - 1) % N]) &&
                   !((state_q[(i + 1) % N] == HUNGRY) && !r_wins[i]);
    end
  end

  // Next-state for every philosopher, computed from current states only.
  always_comb begin
    pending_d   = pending_q;
    violation_d = violation_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      wait_d[i]  = '0;
      case (state_q[i])
        READING: begin
          if (state_q[(i + 1) % N] == THINKING) state_d[i] = THINKING;
        end
        THINKING: begin
          // Reading is contagious from the right and outranks hunger.
          if (state_q[(i + N - 1) % N] == READING) state_d[i] = READING;
          else if (hungry_req[i])                  state_d[i] = HUNGRY;
        end
        EATING: begin
          if (done_req[i]) state_d[i] = THINKING;
        end
        HUNGRY: begin
          if (can_eat[i]) state_d[i] = EATING;
        end
        default: state_d[i] = state_q[i];
      endcase

      // Counts on the current state, so the leaving edge still increments.
      if (state_q[i] == HUNGRY) begin
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? WAIT_MAX : wait_q[i] + WAIT_ONE;
      end

      if (state_q[i] == HUNGRY)        pending_d[i] = 1'b1;
      else if (state_q[i] == THINKING) pending_d[i] = 1'b0;

      if ((state_q[i] == EATING) && (state_q[(i + 1) % N] == EATING)) begin
        violation_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= phil_state_e'(INIT[2*i +: 2]);
        wait_q[i]  <= '0;
      end
      pending_q   <= '0;
      violation_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        wait_q[i]  <= wait_d[i];
      end
      pending_q   <= pending_d;
      violation_q <= violation_d;
    end
  end

  always_comb begin
    state_o   = '0;
    starved_o = '0;
    for (int i = 0; i < N; i++) begin
      state_o[2*i +: 2] = state_q[i];
      starved_o[i]      = (wait_q[i] >= WAIT_LIM);
    end
  end

  assign pending_o   = pending_q;
  assign violation_o = violation_q;

endmodule

// File: tb/tb_diners_ring.sv
// Bench for diners_ring. Several configurations run side by side on one
// clock and reset; each is tracked by a rule-level reference model built on
// plain integer arrays. Directed scenarios add fixed expectations on top.
module tb_diners_ring;

  localparam int NI = 9;
  localparam int          N_TAB [NI] = '{3, 4, 4, 3, 3, 5, 8, 8, 3};
  localparam int          P_TAB [NI] = '{0, 0, 1, 0, 0, 1, 0, 1, 1};
  localparam logic [15:0] I_TAB [NI] = '{16'h001E, 16'h0000, 16'h0000,
                                         16'h0003, 16'h000A, 16'h0000,
                                         16'h0000, 16'h0000, 16'h0000};
  localparam int TH = 0, HU = 1, EA = 2, RE = 3;
  localparam int LIM = 8, WMAX = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][7:0]  hq, dq;
  logic [NI-1:0][15:0] st_w;
  logic [NI-1:0][7:0]  pd_w, sv_w;
  logic [NI-1:0]       vi_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NN = N_TAB[g];
    logic [2*NN-1:0] so;
    logic [NN-1:0]   po, sto;
    logic            vo;
    diners_ring #(
      .N(NN), .WAIT_W(4), .STARVE_LIM(LIM), .PRIO_EN(P_TAB[g]),
      .INIT(I_TAB[g][2*NN-1:0])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .hungry_req(hq[g][NN-1:0]), .done_req(dq[g][NN-1:0]),
      .state_o(so), .pending_o(po), .starved_o(sto), .violation_o(vo)
    );
    assign st_w[g] = 16'(so);
    assign pd_w[g] = 8'(po);
    assign sv_w[g] = 8'(sto);
    assign vi_w[g] = vo;
  end

  // reference model
  int ms [NI][8], mw [NI][8], mp [NI][8];
  int nx_s [NI][8], nx_w [NI][8], nx_p [NI][8];
  bit mv [NI], nx_v [NI];

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Does 'other' take the contention against adjacent 'me'? The older
  // philosopher wins when age priority is on and the ages differ; otherwise
  // the right-hand member of the pair wins.
  function automatic bit other_wins(int k, int other, int me);
    if (P_TAB[k] != 0 && mw[k][other] != mw[k][me]) return mw[k][other] > mw[k][me];
    return other == (me + N_TAB[k] - 1) % N_TAB[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N_TAB[k]; i++) begin
        ms[k][i] = int'(I_TAB[k][2*i +: 2]);
        mw[k][i] = 0;
        mp[k][i] = 0;
      end
      mv[k] = 1'b0;
    end
  endtask

  task automatic model_calc();
    for (int k = 0; k < NI; k++) begin
      int n;
      n = N_TAB[k];
      nx_v[k] = mv[k];
      for (int i = 0; i < n; i++) begin
        int l, r;
        bit ok;
        l = (i + 1) % n;
        r = (i + n - 1) % n;
        nx_s[k][i] = ms[k][i];
        case (ms[k][i])
          RE: if (ms[k][l] == TH) nx_s[k][i] = TH;
          TH: begin
            if (ms[k][r] == RE)  nx_s[k][i] = RE;
            else if (hq[k][i])   nx_s[k][i] = HU;
          end
          EA: if (dq[k][i]) nx_s[k][i] = TH;
          default: begin
            ok = (ms[k][l] != EA) && (ms[k][r] != EA);
            if (ms[k][r] == HU && other_wins(k, r, i)) ok = 1'b0;
            if (ms[k][l] == HU && other_wins(k, l, i)) ok = 1'b0;
            if (ok) nx_s[k][i] = EA;
          end
        endcase
        nx_w[k][i] = (ms[k][i] == HU) ? ((mw[k][i] + 1 > WMAX) ? WMAX : mw[k][i] + 1) : 0;
        nx_p[k][i] = (ms[k][i] == HU) ? 1 : (ms[k][i] == TH) ? 0 : mp[k][i];
        if (ms[k][i] == EA && ms[k][l] == EA) nx_v[k] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N_TAB[k]; i++) begin
        ms[k][i] = nx_s[k][i];
        mw[k][i] = nx_w[k][i];
        mp[k][i] = nx_p[k][i];
      end
      mv[k] = nx_v[k];
    end
  endtask

  // scoreboard: expected values of every instance queued, then compared
  task automatic compare_all();
    logic [31:0] exp_q[$];
    for (int k = 0; k < NI; k++) begin
      logic [15:0] es;
      logic [7:0]  ep, esv;
      es = '0; ep = '0; esv = '0;
      for (int i = 0; i < N_TAB[k]; i++) begin
        es[2*i +: 2] = 2'(ms[k][i]);
        ep[i]        = (mp[k][i] != 0);
        esv[i]       = (mw[k][i] >= LIM);
      end
      exp_q.push_back(32'(es));
      exp_q.push_back(32'(ep));
      exp_q.push_back(32'(esv));
      exp_q.push_back(32'(mv[k]));
    end
    for (int k = 0; k < NI; k++) begin
      check($sformatf("model_state[%0d]", k),   32'(st_w[k]), exp_q.pop_front());
      check($sformatf("model_pending[%0d]", k), 32'(pd_w[k]), exp_q.pop_front());
      check($sformatf("model_starved[%0d]", k), 32'(sv_w[k]), exp_q.pop_front());
      check($sformatf("model_viol[%0d]", k),    32'(vi_w[k]), exp_q.pop_front());
    end
  endtask

  // driver tasks: called just after a negedge, inputs already set
  task automatic tick();
    model_calc();
    @(posedge clk);
    model_commit();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    hq = '0;
    dq = '0;
  endtask

  // Reset asserted mid-cycle, checked before the next edge, held across one
  // edge with random inputs, then released at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      hq[k] = 8'($urandom);
      dq[k] = 8'($urandom);
    end
    #1;
    check("rst_state",   32'(st_w[0]), 32'h1E);
    check("rst_pending", 32'(pd_w[0]), 32'h0);
    check("rst_starved", 32'(sv_w[0]), 32'h0);
    check("rst_viol",    32'(vi_w[4]), 32'h0);
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_state", 32'(st_w[0]), 32'h1E);
    compare_all();
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // right deference, N=4, no age priority
    hq[1] = 8'h03; tick(); check("rd_both_hungry", 32'(st_w[1]), 32'h05);
    hq[1] = 8'h00; tick(); check("rd_right_eats",  32'(st_w[1]), 32'h06);
    dq[1] = 8'h01; tick(); check("rd_done",        32'(st_w[1]), 32'h04);
    dq[1] = 8'h00; tick(); check("rd_left_eats",   32'(st_w[1]), 32'h08);

    // age priority: ph1 hungry three cycles before ph0 while ph2 eats
    do_reset();
    hq[2] = 8'h04; tick();
    hq[2] = 8'h00; tick();
    hq[2] = 8'h02; tick();
    hq[2] = 8'h00; tick(); tick();
    hq[2] = 8'h01; tick(); check("age_setup",    32'(st_w[2]), 32'h25);
    hq[2] = 8'h00; dq[2] = 8'h04;
    tick();                check("age_release",  32'(st_w[2]), 32'h05);
    dq[2] = 8'h00; tick(); check("age_old_eats", 32'(st_w[2]), 32'h09);
    tick();                check("age_hold",     32'(st_w[2]), 32'h09);

    // age priority with equal waits: right member wins
    do_reset();
    hq[2] = 8'h04; tick();
    hq[2] = 8'h00; tick();
    hq[2] = 8'h03; tick(); check("tie_setup", 32'(st_w[2]), 32'h25);
    hq[2] = 8'h00; dq[2] = 8'h04;
    tick();                check("tie_right_eats", 32'(st_w[2]), 32'h06);
    dq[2] = 8'h00; tick(); check("tie_hold",       32'(st_w[2]), 32'h06);

    // starvation of ph1 behind an eating ph0
    do_reset();
    hq[1] = 8'h01; tick();
    hq[1] = 8'h00; tick();
    hq[1] = 8'h02; tick();
    check("starve_enter_pending", 32'(pd_w[1][1]), 32'h0);
    hq[1] = 8'h00;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("starve_t%0d", t), 32'(sv_w[1][1]), (t >= LIM) ? 32'h1 : 32'h0);
      if (t == 1) check("starve_pending", 32'(pd_w[1][1]), 32'h1);
    end
    dq[1] = 8'h01; tick(); check("starve_still_hungry", 32'(sv_w[1][1]), 32'h1);
    dq[1] = 8'h00; tick(); check("starve_leave_edge",   32'(sv_w[1][1]), 32'h1);
    check("starve_ph1_eats", 32'(st_w[1][3:2]), 32'h2);
    tick();                check("starve_cleared",      32'(sv_w[1][1]), 32'h0);

    // READING chain, N=3, ph0 starts READING
    do_reset();
    check("read_init", 32'(st_w[3]), 32'h03);
    tick();                check("read_spread",   32'(st_w[3]), 32'h0C);
    tick();                check("read_wrap",     32'(st_w[3]), 32'h30);
    hq[3] = 8'h02; tick(); check("read_ph1_hung", 32'(st_w[3]), 32'h07);
    hq[3] = 8'h00; tick(); check("read_blocked",  32'(st_w[3]), 32'h0B);
    dq[3] = 8'h02; tick(); check("read_held",     32'(st_w[3]), 32'h03);
    dq[3] = 8'h00; tick(); check("read_release",  32'(st_w[3]), 32'h0C);

    // illegal INIT with ph0,ph1 EATING: sticky violation
    do_reset();
    check("viol_pre", 32'(vi_w[4]), 32'h0);
    tick();
    check("viol_set", 32'(vi_w[4]), 32'h1);
    for (int t = 0; t < 6; t++) begin
      hq[4] = 8'($urandom);
      dq[4] = 8'($urandom);
      tick();
      check("viol_sticky", 32'(vi_w[4]), 32'h1);
    end

    // randomized run on all configurations with periodic resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 499) do_reset();
      for (int k = 0; k < NI; k++) begin
        hq[k] = 8'($urandom);
        dq[k] = 8'($urandom & $urandom);
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        if (k != 4) check($sformatf("safety[%0d]", k), 32'(vi_w[k]), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
